cpu_controller: RTL
===================

# cpu_controller

Parametrised Moore state machine that sequences the Simple RISC Machine datapath for one instruction per start request. It sits between the instruction register/decoder and the datapath, and drives register-file, ALU, status and write-back controls. It supersedes the ADD-only controller with:
- the full ALU/MOV instruction set;
- illegal-instruction handling;
- an optional load/store sequence with configurable memory wait.

## Interface
Parameters:
- MEM_WAIT, 1: cycles MEM_RD/MEM_WR are held (legal 1..15); used only with CTRL_MEM_EN.
- ILLEGAL_HALT, 0: 0 = illegal instruction returns to WAIT; 1 = enters HALT until reset.

Ports:
- clk  input  1  rising-edge clock; one clock; reset is synchronous and active-high.
- reset  input  1  synchronous, active-high; forces WAIT.
- s  input  1  start; sampled only in WAIT.
- opcode  input  3  instruction opcode; stable from start until w returns high.
- op  input  2  instruction op field; stable likewise.
- w  output  1  idle/ready; high only in WAIT.
- nsel  output  3  one-hot register select: 001 Rn, 010 Rd, 100 Rm; 000 otherwise.
- vsel  output  4  one-hot write-back source: [3] mdata, [2] sximm8, [1] PC, [0] C.
- loada, loadb, loadc, loads  output  1 each  A/B/C/status register enables.
- asel  output  1  1 = ALU A input forced to 0.
- bsel  output  1  1 = ALU B input is sximm5.
- ALUop  output  2  ALU operation.
- write  output  1  register-file write enable.
- illegal  output  1  illegal-instruction flag.
- mem_rd, mem_wr, load_addr  output  1 each  present only with CTRL_MEM_EN.

## Operation
- Encoding and outputs:
  - Registered one-hot state.
  - All outputs decode from state only (Moore); illegal also decodes from opcode/op in DECODE.
  - Any output not listed for a state is 0.
- WAIT:
  - w=1.
  - s=1 -> DECODE; else stay.
- DECODE: dispatches per instruction.
  - 110/10 MOV imm -> WRITE_IMM.
  - 110/00 MOV reg -> GET_B.
  - 101/11 MVN -> GET_B.
  - 101/00 ADD, 101/01 CMP, 101/10 AND -> GET_A.
  - With CTRL_MEM_EN: 011/00 LDR and 100/00 STR -> GET_A.
  - Anything else is illegal:
    - illegal=1 for the DECODE cycle;
    - then WAIT if ILLEGAL_HALT=0, or HALT if ILLEGAL_HALT=1.
- HALT: w=0, illegal=1; exits only on reset.
- Data-path states:
  - WRITE_IMM: nsel=001, vsel=0100, write=1 -> WAIT.
  - GET_A: nsel=001, loada=1.
    - Next state is GET_B, except LDR/STR -> ADDR.
  - GET_B: nsel=100, loadb=1 -> EXEC.
  - EXEC:
    - MOV reg: asel=1, ALUop=00.
    - Other instructions: ALUop=op.
    - CMP: loads=1, loadc=0 -> WAIT.
    - Others: loadc=1 -> WRITE_REG.
  - WRITE_REG: nsel=010, vsel=0001, write=1 -> WAIT.
- Memory states (CTRL_MEM_EN only):
  - ADDR: bsel=1, ALUop=00, loadc=1 -> LOAD_ADDR.
  - LOAD_ADDR: load_addr=1.
    - LDR -> MEM_RD.
    - STR -> GET_D.
  - MEM_RD: mem_rd=1 for MEM_WAIT cycles -> WRITE_MEM.
  - WRITE_MEM: mem_rd=1, nsel=010, vsel=1000, write=1 -> WAIT.
  - GET_D: nsel=010, loadb=1 -> PASS.
  - PASS: asel=1, ALUop=00, loadc=1 -> MEM_WR.
  - MEM_WR: mem_wr=1 for MEM_WAIT cycles -> WAIT.
- Wait counter:
  - 4 bits, loaded with MEM_WAIT-1 on entry to MEM_RD/MEM_WR.
  - Decrements each cycle in those states; the state exits when the counter is 0.

## Timing
- Reset state:
  - After the reset edge: state WAIT, w=1, all other outputs 0, counter 0.
  - Reset in any state, including mid-wait or HALT, takes effect at the next edge.
- Cycle counts, measured from the edge that samples s=1 to the edge that returns to WAIT:
  - MOV imm: 2.
  - CMP: 4.
  - MOV reg, MVN: 4.
  - ADD, AND: 5.
  - LDR: 5+MEM_WAIT.
  - STR: 6+MEM_WAIT.
  - Illegal instruction (ILLEGAL_HALT=0): 1.
- w behaviour:
  - w falls one cycle after s is sampled.
  - w is high again in the cycle after the last active state.
  - If s is still high in that WAIT cycle, the next instruction starts immediately; no extra idle cycle is required.
- s is ignored in every state except WAIT.

## Configuration
- CTRL_MEM_EN defined:
  - LDR/STR states, counter and mem_rd/mem_wr/load_addr ports are built.
  - MEM_WAIT is honoured.
- CTRL_MEM_EN undefined:
  - Those states and ports are absent.
  - Opcodes 011/100 are treated as illegal.
  - MEM_WAIT is ignored.

## Test plan
- Reset then idle: w=1, all other outputs 0. Then s=1 with 110/10: WRITE_IMM cycle shows nsel=001, vsel=0100, write=1; w=1 two edges after the start.
- ADD (101/00) and CMP (101/01):
  - ADD: loada, loadb, loadc then write in successive cycles, with nsel 001/100/-/010.
  - CMP: loads=1 in EXEC, write never asserted; returns after 4 edges.
- MOV reg (110/00): EXEC has asel=1, ALUop=00; WRITE_REG has vsel=0001, write=1.
- Illegal 111/00:
  - ILLEGAL_HALT=0: illegal pulses one cycle, back in WAIT after 1 edge.
  - ILLEGAL_HALT=1: w=0 and illegal=1 held for 20 cycles; reset then restores w=1.
- CTRL_MEM_EN with MEM_WAIT=3:
  - LDR: mem_rd high 4 consecutive cycles (3 in MEM_RD plus WRITE_MEM), write with vsel=1000; w back after 8 edges.
  - STR: mem_wr high exactly 3 cycles.
- Reset asserted during MEM_WR, and during GET_B: all strobes 0 and w=1 after that edge; a following MOV imm completes normally.

Source files
------------

// File: rtl/cpu_controller_if.sv
// Instruction/control bundle between the decoder side (master) and cpu_controller (slave).
// The memory strobes exist only when CTRL_MEM_EN is defined.
interface cpu_controller_if;
  logic       s;
  logic [2:0] opcode;
  logic [1:0] op;
  logic       w;
  logic [2:0] nsel;
  logic [3:0] vsel;
  logic       loada;
  logic       loadb;
  logic       loadc;
  logic       loads;
  logic       asel;
  logic       bsel;
  logic [1:0] ALUop;
  logic       write;
  logic       illegal;
`ifdef CTRL_MEM_EN
  logic       mem_rd;
  logic       mem_wr;
  logic       load_addr;

  modport master (
    output s, opcode, op,
    input  w, nsel, vsel, loada, loadb, loadc, loads, asel, bsel, ALUop, write, illegal,
           mem_rd, mem_wr, load_addr
  );
  modport slave (
    input  s, opcode, op,
    output w, nsel, vsel, loada, loadb, loadc, loads, asel, bsel, ALUop, write, illegal,
           mem_rd, mem_wr, load_addr
  );
`else
  modport master (
    output s, opcode, op,
    input  w, nsel, vsel, loada, loadb, loadc, loads, asel, bsel, ALUop, write, illegal
  );
  modport slave (
    input  s, opcode, op,
    output w, nsel, vsel, loada, loadb, loadc, loads, asel, bsel, ALUop, write, illegal
  );
`endif
endinterface

// File: rtl/cpu_controller.sv
// Moore sequencer for the Simple RISC Machine datapath, one instruction per start request.
// Load/store sequencing with a MEM_WAIT-cycle memory phase is built when CTRL_MEM_EN is defined.
module cpu_controller #(
  parameter int MEM_WAIT     = 1,
  parameter int ILLEGAL_HALT = 0
) (
  input logic             clk,
  input logic             reset,
  cpu_controller_if.slave ctrl
);

`ifdef CTRL_MEM_EN
  localparam int ST_W = 15;
  localparam logic [3:0] WAIT_LOAD = (MEM_WAIT <= 1)  ? 4'd0  :
                                     (MEM_WAIT >= 15) ? 4'd14 : 4'(MEM_WAIT - 1);
`else
  localparam int ST_W = 8;
  localparam int unused_mem_wait = MEM_WAIT;
`endif
  localparam logic HALT_ON_ILLEGAL = (ILLEGAL_HALT != 0);

  typedef enum logic [ST_W-1:0] {
    S_WAIT      = ST_W'(1'b1),
    S_DECODE    = ST_W'(1'b1) << 1,
    S_HALT      = ST_W'(1'b1) << 2,
    S_WRITE_IMM = ST_W'(1'b1) << 3,
    S_GET_A     = ST_W'(1'b1) << 4,
    S_GET_B     = ST_W'(1'b1) << 5,
    S_EXEC      = ST_W'(1'b1) << 6,
`ifdef CTRL_MEM_EN
    S_WRITE_REG = ST_W'(1'b1) << 7,
    S_ADDR      = ST_W'(1'b1) << 8,
    S_LOAD_ADDR = ST_W'(1'b1) << 9,
    S_MEM_RD    = ST_W'(1'b1) << 10,
    S_WRITE_MEM = ST_W'(1'b1) << 11,
    S_GET_D     = ST_W'(1'b1) << 12,
    S_PASS      = ST_W'(1'b1) << 13,
    S_MEM_WR    = ST_W'(1'b1) << 14
`else
    S_WRITE_REG = ST_W'(1'b1) << 7
`endif
  } state_t;

  state_t     state_r;
  state_t     state_next_s;

  logic       mov_imm_s;
  logic       mov_reg_s;
  logic       mvn_s;
  logic       alu_s;
  logic       cmp_s;
  logic       mem_op_s;
  logic       legal_s;

  logic       w_s;
  logic [2:0] nsel_s;
  logic [3:0] vsel_s;
  logic       loada_s;
  logic       loadb_s;
  logic       loadc_s;
  logic       loads_s;
  logic       asel_s;
  logic       bsel_s;
  logic [1:0] aluop_s;
  logic       write_s;
  logic       illegal_s;

  assign mov_imm_s = (ctrl.opcode == 3'b110) && (ctrl.op == 2'b10);
  assign mov_reg_s = (ctrl.opcode == 3'b110) && (ctrl.op == 2'b00);
  assign mvn_s     = (ctrl.opcode == 3'b101) && (ctrl.op == 2'b11);
  assign alu_s     = (ctrl.opcode == 3'b101) && (ctrl.op != 2'b11);
  assign cmp_s     = (ctrl.opcode == 3'b101) && (ctrl.op == 2'b01);

`ifdef CTRL_MEM_EN
  logic       ldr_s;
  logic       str_s;
  logic       mem_rd_s;
  logic       mem_wr_s;
  logic       load_addr_s;
  logic [3:0] cnt_r;

  assign ldr_s    = (ctrl.opcode == 3'b011) && (ctrl.op == 2'b00);
  assign str_s    = (ctrl.opcode == 3'b100) && (ctrl.op == 2'b00);
  assign mem_op_s = ldr_s | str_s;
`else
  assign mem_op_s = 1'b0;
`endif
  assign legal_s = mov_imm_s | mov_reg_s | mvn_s | alu_s | mem_op_s;

  // Next-state selection; unreachable encodings recover to WAIT.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      S_WAIT: begin
        if (ctrl.s) state_next_s = S_DECODE;
        else        state_next_s = S_WAIT;
      end
      S_DECODE: begin
        if (mov_imm_s)                state_next_s = S_WRITE_IMM;
        else if (mov_reg_s || mvn_s)  state_next_s = S_GET_B;
        else if (alu_s || mem_op_s)   state_next_s = S_GET_A;
        else if (HALT_ON_ILLEGAL)     state_next_s = S_HALT;
        else                          state_next_s = S_WAIT;
      end
      S_HALT:      state_next_s = S_HALT;
      S_WRITE_IMM: state_next_s = S_WAIT;
`ifdef CTRL_MEM_EN
      S_GET_A: begin
        if (mem_op_s) state_next_s = S_ADDR;
        else          state_next_s = S_GET_B;
      end
`else
      S_GET_A:     state_next_s = S_GET_B;
`endif
      S_GET_B:     state_next_s = S_EXEC;
      S_EXEC: begin
        if (cmp_s) state_next_s = S_WAIT;
        else       state_next_s = S_WRITE_REG;
      end
      S_WRITE_REG: state_next_s = S_WAIT;
`ifdef CTRL_MEM_EN
      S_ADDR:      state_next_s = S_LOAD_ADDR;
      S_LOAD_ADDR: begin
        if (ldr_s) state_next_s = S_MEM_RD;
        else       state_next_s = S_GET_D;
      end
      S_MEM_RD: begin
        if (cnt_r == 4'd0) state_next_s = S_WRITE_MEM;
        else               state_next_s = S_MEM_RD;
      end
      S_WRITE_MEM: state_next_s = S_WAIT;
      S_GET_D:     state_next_s = S_PASS;
      S_PASS:      state_next_s = S_MEM_WR;
      S_MEM_WR: begin
        if (cnt_r == 4'd0) state_next_s = S_WAIT;
        else               state_next_s = S_MEM_WR;
      end
`endif
      default:     state_next_s = S_WAIT;
    endcase
  end

  // Output decode of the state being entered, so the registered outputs line up with state_r.
  always_comb begin
    w_s         = 1'b0;
    nsel_s      = 3'b000;
    vsel_s      = 4'b0000;
    loada_s     = 1'b0;
    loadb_s     = 1'b0;
    loadc_s     = 1'b0;
    loads_s     = 1'b0;
    asel_s      = 1'b0;
    bsel_s      = 1'b0;
    aluop_s     = 2'b00;
    write_s     = 1'b0;
    illegal_s   = 1'b0;
`ifdef CTRL_MEM_EN
    mem_rd_s    = 1'b0;
    mem_wr_s    = 1'b0;
    load_addr_s = 1'b0;
`endif
    case (state_next_s)
      S_WAIT:      w_s = 1'b1;
      S_DECODE:    illegal_s = ~legal_s;
      S_HALT:      illegal_s = 1'b1;
      S_WRITE_IMM: begin
        nsel_s  = 3'b001;
        vsel_s  = 4'b0100;
        write_s = 1'b1;
      end
      S_GET_A: begin
        nsel_s  = 3'b001;
        loada_s = 1'b1;
      end
      S_GET_B: begin
        nsel_s  = 3'b100;
        loadb_s = 1'b1;
      end
      S_EXEC: begin
        if (mov_reg_s) begin
          asel_s  = 1'b1;
          aluop_s = 2'b00;
        end else begin
          aluop_s = ctrl.op;
        end
        if (cmp_s) loads_s = 1'b1;
        else       loadc_s = 1'b1;
      end
      S_WRITE_REG: begin
        nsel_s  = 3'b010;
        vsel_s  = 4'b0001;
        write_s = 1'b1;
      end
`ifdef CTRL_MEM_EN
      S_ADDR: begin
        bsel_s  = 1'b1;
        loadc_s = 1'b1;
      end
      S_LOAD_ADDR: load_addr_s = 1'b1;
      S_MEM_RD:    mem_rd_s = 1'b1;
      S_WRITE_MEM: begin
        mem_rd_s = 1'b1;
        nsel_s   = 3'b010;
        vsel_s   = 4'b1000;
        write_s  = 1'b1;
      end
      S_GET_D: begin
        nsel_s  = 3'b010;
        loadb_s = 1'b1;
      end
      S_PASS: begin
        asel_s  = 1'b1;
        loadc_s = 1'b1;
      end
      S_MEM_WR:    mem_wr_s = 1'b1;
`endif
      default:     w_s = 1'b0;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state_r <= S_WAIT;
    else       state_r <= state_next_s;
  end

  // Registered control outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      ctrl.w       <= 1'b1;
      ctrl.nsel    <= 3'b000;
      ctrl.vsel    <= 4'b0000;
      ctrl.loada   <= 1'b0;
      ctrl.loadb   <= 1'b0;
      ctrl.loadc   <= 1'b0;
      ctrl.loads   <= 1'b0;
      ctrl.asel    <= 1'b0;
      ctrl.bsel    <= 1'b0;
      ctrl.ALUop   <= 2'b00;
      ctrl.write   <= 1'b0;
      ctrl.illegal <= 1'b0;
    end else begin
      ctrl.w       <= w_s;
      ctrl.nsel    <= nsel_s;
      ctrl.vsel    <= vsel_s;
      ctrl.loada   <= loada_s;
      ctrl.loadb   <= loadb_s;
      ctrl.loadc   <= loadc_s;
      ctrl.loads   <= loads_s;
      ctrl.asel    <= asel_s;
      ctrl.bsel    <= bsel_s;
      ctrl.ALUop   <= aluop_s;
      ctrl.write   <= write_s;
      ctrl.illegal <= illegal_s;
    end
  end

`ifdef CTRL_MEM_EN
  // Memory strobes and the wait counter; the counter is armed on entry and exits the state at zero.
  always_ff @(posedge clk) begin
    if (reset) begin
      ctrl.mem_rd    <= 1'b0;
      ctrl.mem_wr    <= 1'b0;
      ctrl.load_addr <= 1'b0;
      cnt_r          <= 4'd0;
    end else begin
      ctrl.mem_rd    <= mem_rd_s;
      ctrl.mem_wr    <= mem_wr_s;
      ctrl.load_addr <= load_addr_s;
      if ((state_next_s == S_MEM_RD && state_r != S_MEM_RD) ||
          (state_next_s == S_MEM_WR && state_r != S_MEM_WR)) begin
        cnt_r <= WAIT_LOAD;
      end else if ((state_r == S_MEM_RD || state_r == S_MEM_WR) && cnt_r != 4'd0) begin
        cnt_r <= cnt_r - 4'd1;
      end else begin
        cnt_r <= cnt_r;
      end
    end
  end
`endif

endmodule
